mult_div_unit: RTL and testbench

//   Multicycle integer multiply/divide unit that feeds the HI/LO registers of the multicycle CPU.
//   It is parametrised in operand width and supports signed and unsigned modes for both MULT and DIV.
//   A start/done handshake with the control unit sequences it; divide-by-zero is flagged for the exception path.

---
 rtl/mult_div_unit.sv | 126 ++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed/unsigned multiply/divide unit feeding HI/LO
// Ports: clk; reset (async, active-high); start/op/a/b request, accepted only while idle;
//        busy while an operation runs; done one-cycle result pulse; div0 one-cycle
//        divide-by-zero pulse alongside done; hi/lo result (MULT: product halves,
//        DIV: remainder/quotient), held until the next completed operation.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic               is_div;
    logic               neg_lo;     // sign of product (MULT) or quotient (DIV)
    logic               neg_hi;     // sign of remainder (DIV only): follows the dividend
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;        // MULT: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [CNT_W-1:0]   count;

    // Operand magnitudes; op[0]=0 selects the signed variants
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Shift-add step: add multiplicand to the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right, keeping the carry.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & mag_b};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder and try to
    // subtract; the top bit of the extended difference is the borrow.
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, mag_b};
    assign div_next = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    // Sign fix-up applied once at the end
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_fix = neg_lo ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            div0   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            mag_b  <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op[1] && (b == '0)) begin
                            // Divide by zero: flag immediately, leave hi/lo untouched
                            done <= 1'b1;
                            div0 <= 1'b1;
                        end else begin
                            is_div <= op[1];
                            mag_b  <= b_mag;
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                            count  <= CNT_W'(WIDTH);
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit at WIDTH=32 and WIDTH=8
module tb_mult_div_unit;

    logic        clk;
    logic        rst32, start32, busy32, done32, div032;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        rst8, start8, busy8, done8, div08;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .reset(rst32), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div0(div032), .hi(hi32), .lo(lo32)
    );

    mult_div_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(rst8), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands
    function automatic void model(input int w, input logic [1:0] op, input logic [31:0] av,
                                  input logic [31:0] bv, output logic [31:0] mhi,
                                  output logic [31:0] mlo);
        logic [63:0] mask, p;
        longint ua, ub, sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = longint'({32'd0, av} & mask);
        ub = longint'({32'd0, bv} & mask);
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        if (!op[1]) begin
            p   = op[0] ? 64'(ua * ub) : 64'(sa * sb);
            mhi = 32'((p >> w) & mask);
            mlo = 32'(p & mask);
        end else begin
            if (op[0]) begin q = ua / ub; r = ua % ub; end
            else       begin q = sa / sb; r = sa % sb; end
            mhi = 32'(64'(r) & mask);
            mlo = 32'(64'(q) & mask);
        end
    endfunction

    function automatic logic f_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic logic f_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
    // lat counts cycles after the start-sampling edge: 0 means done right after that edge.
    // poke>0 injects a second start (WIDTH=32 only) while the first operation is running.
    task automatic do_op(input bit w8, input logic [1:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input int poke,
                         output logic [31:0] ghi, output logic [31:0] glo,
                         output logic gdiv0, output int lat, output bit busy_ok);
        if (w8) begin start8 = 1'b1; op8 = op; a8 = av[7:0]; b8 = bv[7:0]; end
        else    begin start32 = 1'b1; op32 = op; a32 = av; b32 = bv; end
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        // Operands may change freely once sampled
        a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom);
        a32 = $urandom; b32 = $urandom; op32 = 2'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!f_done(w8) && lat < 100) begin
            if (!f_busy(w8)) busy_ok = 1'b0;
            if (poke != 0 && lat == poke) begin
                start32 = 1'b1; op32 = 2'b10; a32 = 32'd1000; b32 = 32'd3;
            end else begin
                start32 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start32 = 1'b0;
        if (f_busy(w8)) busy_ok = 1'b0;
        ghi   = w8 ? {24'd0, hi8} : hi32;
        glo   = w8 ? {24'd0, lo8} : lo32;
        gdiv0 = w8 ? div08 : div032;
    endtask

    logic [31:0] ghi, glo, mhi, mlo, phi, plo, ra, rb;
    logic        gdiv0;
    logic [1:0]  rop;
    int          lat;
    bit          bok;

    initial begin
        tbl[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[2] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        tbl[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        tbl[5] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[6] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        tbl[7] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
        tbl[8] = '{2'b01, 32'h00010000, 32'h00010000, 32'd1,        32'd0};

        rst32 = 1'b1; rst8 = 1'b1;
        start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst32 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy32), 32'd0);
        chk("reset_done", 32'(done32), 32'd0);
        chk("reset_div0", 32'(div032), 32'd0);
        chk("reset_hi", hi32, 32'd0);
        chk("reset_lo", lo32, 32'd0);

        // Directed vectors, issued back-to-back in each done cycle
        for (int i = 0; i < 9; i++) begin
            do_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, 0, ghi, glo, gdiv0, lat, bok);
            chk("vec_hi", ghi, tbl[i].hi);
            chk("vec_lo", glo, tbl[i].lo);
            chk("vec_latency", 32'(lat), 32'd33);
            chk("vec_busy", 32'(bok), 32'd1);
            chk("vec_div0", 32'(gdiv0), 32'd0);
        end

        // Divide by zero keeps the prior result
        phi = hi32; plo = lo32;
        for (int k = 0; k < 2; k++) begin
            do_op(1'b0, (k == 0) ? 2'b10 : 2'b11, 32'd5, 32'd0, 0, ghi, glo, gdiv0, lat, bok);
            chk("dz_latency", 32'(lat), 32'd0);
            chk("dz_div0", 32'(gdiv0), 32'd1);
            chk("dz_busy", 32'(busy32), 32'd0);
            chk("dz_hi", ghi, phi);
            chk("dz_lo", glo, plo);
            @(negedge clk);
            chk("dz_done_pulse", 32'(done32), 32'd0);
            chk("dz_div0_pulse", 32'(div032), 32'd0);
        end

        // Second start during an operation is ignored
        model(32, 2'b00, 32'h12345678, 32'hFEDCBA98, mhi, mlo);
        do_op(1'b0, 2'b00, 32'h12345678, 32'hFEDCBA98, 5, ghi, glo, gdiv0, lat, bok);
        chk("ignore_hi", ghi, mhi);
        chk("ignore_lo", glo, mlo);
        chk("ignore_latency", 32'(lat), 32'd33);
        @(negedge clk);
        chk("ignore_no_second_done", 32'(done32), 32'd0);
        chk("ignore_idle", 32'(busy32), 32'd0);

        // Reset in the middle of a multiply
        start32 = 1'b1; op32 = 2'b00; a32 = 32'h0000FFFF; b32 = 32'h00012345;
        @(negedge clk);
        start32 = 1'b0;
        repeat (9) @(negedge clk);
        rst32 = 1'b1;
        #1;
        chk("midrst_hi", hi32, 32'd0);
        chk("midrst_lo", lo32, 32'd0);
        chk("midrst_busy", 32'(busy32), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midrst_done", 32'(done32), 32'd0);
        end
        rst32 = 1'b0;
        do_op(1'b0, 2'b00, 32'd6, 32'd7, 0, ghi, glo, gdiv0, lat, bok);
        chk("post_rst_lo", glo, 32'd42);
        chk("post_rst_hi", ghi, 32'd0);
        chk("post_rst_latency", 32'(lat), 32'd33);

        // WIDTH=8 random sweep, all ops including zero divisors
        phi = 32'd0; plo = 32'd0;
        for (int n = 0; n < 300; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 32'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin ra = 32'h80; rb = 32'hFF; end
            do_op(1'b1, rop, ra, rb, 0, ghi, glo, gdiv0, lat, bok);
            if (rop[1] && rb == 32'd0) begin
                chk("r8_dz_latency", 32'(lat), 32'd0);
                chk("r8_dz_div0", 32'(gdiv0), 32'd1);
                chk("r8_dz_hi", ghi, phi);
                chk("r8_dz_lo", glo, plo);
            end else begin
                model(8, rop, ra, rb, mhi, mlo);
                chk("r8_hi", ghi, mhi);
                chk("r8_lo", glo, mlo);
                chk("r8_latency", 32'(lat), 32'd9);
                chk("r8_div0", 32'(gdiv0), 32'd0);
                if (rop[1]) chk("r8_div_identity", (glo * rb + ghi) & 32'hFF, ra);
                phi = ghi; plo = glo;
            end
            chk("r8_busy", 32'(bok), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
